// File: rtl/dn_stream_if.sv
// dn_stream_if
// Bundles the host-side byte stream handshake and the ROM download bus.
// The loader drives the download bus and the stream ready, so it uses the
// master modport. The host source / ROM consumer side uses the slave modport.
//   in_data[7:0]   stream byte from the host source
//   in_valid       in_data is valid
//   in_ready       loader accepts in_data this cycle
//   dn_addr        ROM write address
//   dn_data[7:0]   ROM write data
//   dn_wr          one-cycle write strobe
//   dn_index[7:0]  target ROM select taken from the packet header
//   dn_download    packet in progress (holds the CPU in reset upstream)
//   done           one-cycle end-of-packet pulse
//   err            sticky oversize flag
interface dn_stream_if #(
    parameter int ADDR_W = 14
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] dn_addr;
    logic [7:0]        dn_data;
    logic              dn_wr;
    logic [7:0]        dn_index;
    logic              dn_download;
    logic              done;
    logic              err;

    modport master (
        input  in_data, in_valid,
        output in_ready, dn_addr, dn_data, dn_wr, dn_index, dn_download, done, err
    );

    modport slave (
        output in_data, in_valid,
        input  in_ready, dn_addr, dn_data, dn_wr, dn_index, dn_download, done, err
    );
endinterface

// File: rtl/dn_stream_loader.sv
// dn_stream_loader
// Turns a framed byte stream (index, LEN lo, LEN hi, LEN payload bytes) into
// paced single-cycle ROM write strobes on the download bus.
//   clk_sys  system clock, rising edge
//   reset    asynchronous, active-high
//   bus      dn_stream_if master: stream handshake in, download bus out
// Parameters:
//   ADDR_W   width of dn_addr; one packet can fill 2^ADDR_W bytes (ADDR_W <= 16)
//   WR_GAP   idle cycles forced between accepted payload bytes (>= 1)
module dn_stream_loader #(
    parameter int ADDR_W = 14,
    parameter int WR_GAP = 3
) (
    input  logic        clk_sys,
    input  logic        reset,
    dn_stream_if.master bus
);
    localparam int          GAP_W = $clog2(WR_GAP + 1);
    localparam logic [16:0] CAP   = 17'(2 ** ADDR_W);

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        GAP,
        FIN
    } state_t;

    state_t           state;
    logic [15:0]      len;
    logic [16:0]      cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             xfer;

    assign xfer = bus.in_valid && bus.in_ready;

    // Packet FSM. in_ready is registered, so every transition also sets the
    // ready value that belongs to the state being entered. cnt is one bit
    // wider than the address so bytes past the ROM capacity can be counted
    // and dropped without wrapping back onto address 0.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            len             <= '0;
            cnt             <= '0;
            gap_cnt         <= '0;
            bus.in_ready    <= 1'b0;
            bus.dn_addr     <= '0;
            bus.dn_data     <= '0;
            bus.dn_wr       <= 1'b0;
            bus.dn_index    <= '0;
            bus.dn_download <= 1'b0;
            bus.done        <= 1'b0;
            bus.err         <= 1'b0;
        end else begin
            bus.dn_wr <= 1'b0;
            bus.done  <= 1'b0;
            case (state)
                IDLE: begin
                    bus.in_ready <= 1'b1;
                    if (xfer) begin
                        bus.dn_index    <= bus.in_data;
                        bus.err         <= 1'b0;
                        bus.dn_download <= 1'b1;
                        state           <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (xfer) begin
                        len[7:0] <= bus.in_data;
                        state    <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (xfer) begin
                        len[15:8] <= bus.in_data;
                        cnt       <= '0;
                        if ({1'b0, bus.in_data, len[7:0]} > CAP) begin
                            bus.err <= 1'b1;
                        end
                        // An empty packet skips straight to the end pulse.
                        if ({bus.in_data, len[7:0]} == 16'd0) begin
                            bus.in_ready <= 1'b0;
                            state        <= FIN;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        if (cnt < CAP) begin
                            bus.dn_addr <= cnt[ADDR_W-1:0];
                            bus.dn_data <= bus.in_data;
                            bus.dn_wr   <= 1'b1;
                        end
                        cnt          <= cnt + 17'd1;
                        bus.in_ready <= 1'b0;
                        if (cnt + 17'd1 == {1'b0, len}) begin
                            state <= FIN;
                        end else begin
                            gap_cnt <= GAP_W'(WR_GAP);
                            state   <= GAP;
                        end
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt - GAP_W'(1);
                    if (gap_cnt == GAP_W'(1)) begin
                        bus.in_ready <= 1'b1;
                        state        <= DATA;
                    end
                end
                FIN: begin
                    // Lands one cycle after the last write strobe, so
                    // dn_download still covers that strobe.
                    bus.done        <= 1'b1;
                    bus.dn_download <= 1'b0;
                    bus.in_ready    <= 1'b1;
                    state           <= IDLE;
                end
                default: begin
                    bus.in_ready <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/dn_stream_loader.md
Name: dn_stream_loader

Overview:
- Transmitter side of the ROM download bus (dn_addr/dn_data/dn_wr/dn_index) consumed by the system module.
- Accepts a framed byte stream over a valid/ready handshake from a host-side source, for example an HPS ioctl bridge or a UART receiver.
- Produces paced single-cycle write strobes into the program ROM (index 0) or the character ROM (index 1).
- Drives dn_download so the top level can hold the CPU in reset while a download is in progress.

Parameters:
- ADDR_W, 14, width of dn_addr; capacity of one packet is 2^ADDR_W bytes.
- WR_GAP, 3, idle cycles forced between accepted payload bytes; must be >= 1.

Ports:
- clk_sys  input  1  system clock; everything is rising-edge.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts in_data this cycle.
- dn_addr  output  ADDR_W  write address.
- dn_data  output  8  write data.
- dn_wr  output  1  one-cycle write strobe.
- dn_index  output  8  target select, latched from the packet header.
- dn_download  output  1  packet in progress.
- done  output  1  one-cycle pulse at end of packet.
- err  output  1  sticky oversize flag; cleared at the next header.

Behaviour:
- Clock and reset: one clock, clk_sys. reset is asynchronous and active-high; assertion immediately forces every output to 0, the FSM to IDLE, and all counters to 0.
- Transfer rule: a byte transfers on a clk_sys edge where in_valid && in_ready. in_data is sampled only on a transfer.
- Packet format: byte0 = index; byte1 = LEN[7:0]; byte2 = LEN[15:8]; then LEN payload bytes. LEN = 0 is a legal empty packet.
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, GAP, FIN.
- IDLE: in_ready=1. On transfer: dn_index <= byte, err <= 0, dn_download <= 1, go to LEN_LO.
- LEN_LO: in_ready=1. On transfer: len[7:0] <= byte, go to LEN_HI.
- LEN_HI: in_ready=1. On transfer: len[15:8] <= byte, cnt <= 0. Next state is FIN if LEN=0, else DATA. Set err <= 1 if LEN > 2^ADDR_W.
- DATA: in_ready=1. On transfer:
  - If cnt < 2^ADDR_W: dn_addr <= cnt[ADDR_W-1:0], dn_data <= byte, and dn_wr is asserted for exactly the next cycle (latency 1 from the transfer edge).
  - If cnt >= 2^ADDR_W: the byte is consumed and discarded, and no dn_wr is issued.
  - In both cases cnt <= cnt+1 (cnt is 17 bits, no wrap). Go to FIN if cnt+1 == LEN, else to GAP with gap counter <= WR_GAP.
- GAP: in_ready=0. Decrement the gap counter and return to DATA when it reaches 0. Net result: at most one payload byte per WR_GAP+1 cycles.
- FIN: in_ready=0. Entered after the final transfer, or directly from LEN_HI when LEN=0.
  - One cycle after entry (the cycle the final dn_wr is visible, if any), pulse done=1 for 1 cycle, drop dn_download to 0, go to IDLE.
  - dn_download therefore covers the last dn_wr.
- Held outputs: dn_addr, dn_data and dn_index hold their last values between strobes and after done. dn_wr is 0 in every cycle not described above.
- in_valid low in any state: wait indefinitely with no timeout, holding outputs and state.
- Reset mid-packet: the partial packet is abandoned and no done pulse is produced. Already-written ROM bytes are not undone.
- dn_index values other than 0/1 are passed through unchanged; decoding belongs to the consumer.

Test Plan:
- Packet 00 04 00 AA BB CC DD, in_valid held high -> dn_wr pulses at addr 0..3 with data AA,BB,CC,DD; pulses spaced exactly WR_GAP+1=4 cycles apart. dn_index=0 throughout. dn_download high from the cycle after the header byte through the last strobe. done pulses once, 1 cycle after the last strobe, coinciding with dn_download falling.
- Packet 01 00 00 -> no dn_wr; dn_index=1; done pulses one cycle after the LEN_HI transfer; err=0.
- Packet 01 02 00 11 22 with in_valid toggled 1-0-0-1 on payload -> exactly 2 writes (addr0=11, addr1=22); no extra strobes during stalls.
- Packet 00 01 40 followed by 16385 bytes (LEN=0x4001) -> err=1 after header; 16384 writes covering addr 0..3FFF; 16385th byte accepted without dn_wr; done pulses; next header clears err.
- reset asserted asynchronously mid-way through the payload of a 16-byte packet -> in the same cycle dn_wr, dn_download, in_ready and done are 0. After release, a fresh packet 00 01 00 5A writes 5A at addr 0 normally.
- Two back-to-back packets (00 01 00 77, then 01 01 00 88) -> addr0=77 with index 0, then addr0=88 with index 1; two separate done pulses; in_ready=1 in IDLE immediately after the first done.
